mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one pipelined 32-bit multiplier (same arithmetic as the `mul` builtin: low WIDTH bits of in0*in1) among NUM_REQ requesters emitted by the HLS scheduler.
- Grants one request per cycle, round-robin, and tags each operation with its requester index.
- Returns each product to the originating requester exactly LAT cycles after acceptance.
- Sits between scheduled datapath states and a single multiplier instance, replacing per-state `mul` copies.

Parameters:
- NUM_REQ, 4, number of requesters; 2..16.
- WIDTH, 32, operand/result width.
- LAT, 3, cycles from acceptance to resp_valid; ≥1.
- TAG_W, $clog2(NUM_REQ), requester-index width (derived, not overridable).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request strobe.
- req_in0  input  NUM_REQ*WIDTH  operand 0; requester i at bits [i*WIDTH +: WIDTH].
- req_in1  input  NUM_REQ*WIDTH  operand 1; same packing.
- req_ready  output  NUM_REQ  one-hot grant; combinational from req_valid and rr_ptr.
- resp_valid  output  NUM_REQ  one-hot; bit i means resp_out belongs to requester i this cycle.
- resp_out  output  WIDTH  product, low WIDTH bits of in0*in1, unsigned.
- busy  output  1  any pipeline stage holds a valid operation.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All stage valid bits 0; rr_ptr = 0; resp_valid = 0; resp_out = 0; busy = 0.
  - Operations in flight when rst asserts are discarded; no response is ever produced for them.
- Handshake:
  - Transfer on req_valid[i] & req_ready[i] at a rising edge.
  - A requester holds valid and operands stable until ready.
  - req_ready never asserts without its req_valid.
  - No backpressure on responses; the consumer must take resp_out in the cycle resp_valid is high.
- Arbitration:
  - Grant the first i with req_valid[i] set, searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - At most one grant per cycle.
  - On a grant to g, rr_ptr <= (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
  - No grant: rr_ptr holds.
  - Starvation bound: a held request is granted within NUM_REQ cycles.
- Pipeline:
  - Accepted operands enter stage 0 with a tag (granted index, TAG_W bits) and valid bit.
  - Stages 0..LAT-1 shift every cycle, unconditionally.
  - The product is computed on registered stage-0 operands and carried through the remaining stages. Retiming inside is free, but total latency must be exact.
  - Acceptance at edge t gives resp_valid[tag] = 1 and resp_out = product during the cycle after edge t+LAT-1 (LAT edges later).
  - resp_out holds its last value when no stage exits valid. It does not return to 0.
- Throughput: one operation per cycle sustained; back-to-back grants to the same requester are allowed when it is the only one requesting.
- Arithmetic: operands are unsigned; the product is truncated to WIDTH bits, so overflow wraps silently. 0xFFFFFFFF*2 = 0xFFFFFFFE.
- busy is the OR of all stage valid bits. It is independent of the request inputs.
- Simultaneous events:
  - A new grant and a response exit in the same cycle both occur.
  - A requester may receive a response and be granted again in the same cycle.

Decomposition:
- Package mul_share_pkg:
  - default NUM_REQ/WIDTH/LAT constants;
  - function clog2_safe (returns 1 for NUM_REQ=2);
  - typedef for a stage record {valid, tag, data}.
- Sub-module rr_arbiter:
  - NUM_REQ-wide round-robin grant plus pointer register.
  - Ports: clk, rst, req, grant, grant_idx, any_grant.
- Pipeline and multiply stay in the top.

Test Plan:
1. Reset/idle: hold rst 3 cycles, release with req_valid=0 → req_ready=0, resp_valid=0, resp_out=0, busy=0 for 10 cycles.
2. Single op: req 1 valid with 7 and 6 for one accepted cycle → req_ready=4'b0010 that cycle; resp_valid=4'b0010, resp_out=42 exactly LAT=3 cycles later; busy high for 3 cycles.
3. Round-robin: all four request continuously with in0=i+1, in1=10 → grants 0,1,2,3,0,… one per cycle; responses 10,20,30,40 in that order with matching one-hot resp_valid.
4. Pointer wrap/skip: rr_ptr=3, only requesters 1 and 3 valid → grant 3, then 1, then 3.
5. Overflow: 0xFFFFFFFF × 2 → resp_out=0xFFFFFFFE; 0x10000 × 0x10000 → 0.
6. Reset mid-flight: accept 3 ops, assert rst one cycle later → no resp_valid ever appears for them; after release, a new op 5×5 returns 25 at LAT.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared constants and helpers for the shared-multiplier arbiter.
// The stage record below is the default-configuration view of one pipeline entry.
package mul_share_pkg;

    localparam int DEFAULT_NUM_REQ = 4;
    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_LAT     = 3;

    // Index width that never collapses to zero bits for small requester counts.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_TAG_W = clog2_safe(DEFAULT_NUM_REQ);

    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_TAG_W-1:0] tag;
        logic [DEFAULT_WIDTH-1:0] data;
    } stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin single-grant arbiter; the search starts at the pointer and the
// pointer moves one past the winner, so a held request waits at most NUM_REQ cycles.
module rr_arbiter
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    output logic [NUM_REQ-1:0]               grant,
    output logic [clog2_safe(NUM_REQ)-1:0]   grant_idx,
    output logic                             any_grant
);

    localparam int TAG_W = clog2_safe(NUM_REQ);

    logic [TAG_W-1:0] ptr_q, ptr_d;

    always_comb begin
        int               pos;
        logic [TAG_W-1:0] idx;
        // NOTE: every comb output gets a default first, so no path leaves a latch.
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            pos = int'(ptr_q) + off;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            idx = TAG_W'(pos);
            if (!any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (any_grant) begin
            if (grant_idx == TAG_W'(NUM_REQ - 1)) ptr_d = '0;
            else                                  ptr_d = grant_idx + TAG_W'(1);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// One pipelined multiplier shared round-robin by NUM_REQ requesters; each
// product returns to its requester exactly LAT cycles after acceptance.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int LAT     = DEFAULT_LAT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_in0,
    input  logic [NUM_REQ*WIDTH-1:0] req_in1,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_out,
    output logic                     busy
);

    localparam int TAG_W = clog2_safe(NUM_REQ);

    // Parameterised form of the package stage record.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] data;
    } pipe_stage_t;

    logic [NUM_REQ-1:0] grant;
    logic [TAG_W-1:0]   grant_idx;
    logic               any_grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign req_ready = grant;

    logic [WIDTH-1:0] sel_in0, sel_in1;

    always_comb begin
        sel_in0 = '0;
        sel_in1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_in0 = req_in0[i*WIDTH +: WIDTH];
                sel_in1 = req_in1[i*WIDTH +: WIDTH];
            end
        end
    end

    // Stage 0 holds the raw operands; they only change on a grant, which keeps
    // the product stable between operations when LAT is 1.
    logic             s0_valid_q;
    logic [TAG_W-1:0] s0_tag_q;
    logic [WIDTH-1:0] s0_a_q, s0_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_tag_q   <= '0;
            s0_a_q     <= '0;
            s0_b_q     <= '0;
        end else begin
            s0_valid_q <= any_grant;
            s0_tag_q   <= grant_idx;
            if (any_grant) begin
                s0_a_q <= sel_in0;
                s0_b_q <= sel_in1;
            end
        end
    end

    logic [WIDTH-1:0] product;
    assign product = s0_a_q * s0_b_q;

    logic             out_valid;
    logic [TAG_W-1:0] out_tag;
    logic [WIDTH-1:0] out_data;
    logic             tail_busy;

    generate
        if (LAT == 1) begin : g_lat1
            assign out_valid = s0_valid_q;
            assign out_tag   = s0_tag_q;
            assign out_data  = product;
            assign tail_busy = 1'b0;
        end else begin : g_pipe
            pipe_stage_t stage_q [1:LAT-1];

            // NOTE: the data fields are reset too, because resp_out must read 0 after reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 1; k < LAT; k++) stage_q[k] <= '0;
                end else begin
                    stage_q[1].valid <= s0_valid_q;
                    stage_q[1].tag   <= s0_tag_q;
                    if (s0_valid_q) stage_q[1].data <= product;
                    for (int k = 2; k < LAT; k++) begin
                        stage_q[k].valid <= stage_q[k-1].valid;
                        stage_q[k].tag   <= stage_q[k-1].tag;
                        if (stage_q[k-1].valid) stage_q[k].data <= stage_q[k-1].data;
                    end
                end
            end

            always_comb begin
                tail_busy = 1'b0;
                for (int k = 1; k < LAT; k++) tail_busy = tail_busy | stage_q[k].valid;
            end

            assign out_valid = stage_q[LAT-1].valid;
            assign out_tag   = stage_q[LAT-1].tag;
            assign out_data  = stage_q[LAT-1].data;
        end
    endgenerate

    // Data only advances behind a valid entry, so resp_out holds the last product.
    always_comb begin
        resp_valid = '0;
        if (out_valid) resp_valid[out_tag] = 1'b1;
    end

    assign resp_out = out_data;
    assign busy     = s0_valid_q | tail_busy;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter (NUM_REQ=4, WIDTH=32, LAT=3): a per-cycle
// vector table for arbitration and latency, plus hand sequences for reset cases.
module tb_mul_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int LAT     = 3;
    localparam int NVEC    = 31;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_in0;
    logic [NUM_REQ*WIDTH-1:0] req_in1;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [WIDTH-1:0]         resp_out;
    logic                     busy;

    mul_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .LAT     (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_in0    (req_in0),
        .req_in1    (req_in1),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_out   (resp_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   v;
        logic [127:0] a;
        logic [127:0] b;
        logic [3:0]   rdy;
        logic [3:0]   rv;
        logic [31:0]  out;
        logic         bsy;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic logic [127:0] pk(input logic [31:0] x0, x1, x2, x3);
        return {x3, x2, x1, x0};
    endfunction

    function automatic vec_t row(input logic [3:0] v, input logic [127:0] a, b,
                                 input logic [3:0] rdy, rv, input logic [31:0] out,
                                 input logic bsy);
        vec_t r;
        r.v = v; r.a = a; r.b = b; r.rdy = rdy; r.rv = rv; r.out = out; r.bsy = bsy;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Inputs change mid-cycle; registered outputs and combinational ready are stable by #1.
    task automatic drive(input logic [3:0] v, input logic [127:0] a, b);
        @(negedge clk);
        req_valid = v;
        req_in0   = a;
        req_in1   = b;
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] rdy, rv,
                             input logic [31:0] out, input logic bsy);
        check({tag, " ready"}, 32'(req_ready), 32'(rdy));
        check({tag, " resp_valid"}, 32'(resp_valid), 32'(rv));
        check({tag, " resp_out"}, resp_out, out);
        check({tag, " busy"}, 32'(busy), 32'(bsy));
    endtask

    initial begin
        logic [127:0] z;
        z = '0;

        // single op, pointer move, round-robin, wrap/skip, overflow
        vecs[0]  = row(4'b0010, pk(0, 7, 0, 0), pk(0, 6, 0, 0), 4'b0010, 4'b0000, 0, 0);
        vecs[1]  = row(4'b0000, z, z, 4'b0000, 4'b0000, 0, 1);
        vecs[2]  = row(4'b0000, z, z, 4'b0000, 4'b0000, 0, 1);
        vecs[3]  = row(4'b1000, pk(0, 0, 0, 1), pk(0, 0, 0, 1), 4'b1000, 4'b0010, 42, 1);
        vecs[4]  = row(4'b0000, z, z, 4'b0000, 4'b0000, 42, 1);
        vecs[5]  = row(4'b0000, z, z, 4'b0000, 4'b0000, 42, 1);
        vecs[6]  = row(4'b0000, z, z, 4'b0000, 4'b1000, 1, 1);
        vecs[7]  = row(4'b1111, pk(1, 2, 3, 4), pk(10, 10, 10, 10), 4'b0001, 4'b0000, 1, 0);
        vecs[8]  = row(4'b1111, pk(1, 2, 3, 4), pk(10, 10, 10, 10), 4'b0010, 4'b0000, 1, 1);
        vecs[9]  = row(4'b1111, pk(1, 2, 3, 4), pk(10, 10, 10, 10), 4'b0100, 4'b0000, 1, 1);
        vecs[10] = row(4'b1111, pk(1, 2, 3, 4), pk(10, 10, 10, 10), 4'b1000, 4'b0001, 10, 1);
        vecs[11] = row(4'b1111, pk(1, 2, 3, 4), pk(10, 10, 10, 10), 4'b0001, 4'b0010, 20, 1);
        vecs[12] = row(4'b1111, pk(1, 2, 3, 4), pk(10, 10, 10, 10), 4'b0010, 4'b0100, 30, 1);
        vecs[13] = row(4'b0000, z, z, 4'b0000, 4'b1000, 40, 1);
        vecs[14] = row(4'b0000, z, z, 4'b0000, 4'b0001, 10, 1);
        vecs[15] = row(4'b0000, z, z, 4'b0000, 4'b0010, 20, 1);
        vecs[16] = row(4'b0000, z, z, 4'b0000, 4'b0000, 20, 0);
        vecs[17] = row(4'b0100, pk(0, 0, 2, 0), pk(0, 0, 3, 0), 4'b0100, 4'b0000, 20, 0);
        vecs[18] = row(4'b1010, pk(0, 11, 0, 13), pk(0, 2, 0, 2), 4'b1000, 4'b0000, 20, 1);
        vecs[19] = row(4'b1010, pk(0, 11, 0, 13), pk(0, 2, 0, 2), 4'b0010, 4'b0000, 20, 1);
        vecs[20] = row(4'b1010, pk(0, 11, 0, 13), pk(0, 2, 0, 2), 4'b1000, 4'b0100, 6, 1);
        vecs[21] = row(4'b0000, z, z, 4'b0000, 4'b1000, 26, 1);
        vecs[22] = row(4'b0000, z, z, 4'b0000, 4'b0010, 22, 1);
        vecs[23] = row(4'b0000, z, z, 4'b0000, 4'b1000, 26, 1);
        vecs[24] = row(4'b0000, z, z, 4'b0000, 4'b0000, 26, 0);
        vecs[25] = row(4'b0001, pk(32'hFFFF_FFFF, 0, 0, 0), pk(2, 0, 0, 0), 4'b0001, 4'b0000, 26, 0);
        vecs[26] = row(4'b0010, pk(0, 32'h1_0000, 0, 0), pk(0, 32'h1_0000, 0, 0), 4'b0010, 4'b0000, 26, 1);
        vecs[27] = row(4'b0000, z, z, 4'b0000, 4'b0000, 26, 1);
        vecs[28] = row(4'b0000, z, z, 4'b0000, 4'b0001, 32'hFFFF_FFFE, 1);
        vecs[29] = row(4'b0000, z, z, 4'b0000, 4'b0010, 0, 1);
        vecs[30] = row(4'b0000, z, z, 4'b0000, 4'b0000, 0, 0);

        // Reset and idle
        rst       = 1'b1;
        req_valid = '0;
        req_in0   = '0;
        req_in1   = '0;
        repeat (3) @(negedge clk);
        #1;
        check_all("in_reset", 4'b0000, 4'b0000, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(4'b0000, z, z);
            check_all($sformatf("idle%0d", i), 4'b0000, 4'b0000, 0, 0);
        end

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].v, vecs[i].a, vecs[i].b);
            check_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].rv, vecs[i].out, vecs[i].bsy);
        end

        // Reset mid-flight: pointer is at 2, so grants go 2, 3, 0.
        drive(4'b1111, pk(3, 4, 5, 6), pk(7, 7, 7, 7));
        check("mid grant a", 32'(req_ready), 32'(4'b0100));
        drive(4'b1111, pk(3, 4, 5, 6), pk(7, 7, 7, 7));
        check("mid grant b", 32'(req_ready), 32'(4'b1000));
        drive(4'b1111, pk(3, 4, 5, 6), pk(7, 7, 7, 7));
        check("mid grant c", 32'(req_ready), 32'(4'b0001));
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = '0;
        #1;
        check_all("mid_rst", 4'b0000, 4'b0000, 0, 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("mid_rst hold resp_valid", 32'(resp_valid), 32'(0));
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(4'b0000, z, z);
            check_all($sformatf("post_rst%0d", i), 4'b0000, 4'b0000, 0, 0);
        end
        drive(4'b0001, pk(5, 0, 0, 0), pk(5, 0, 0, 0));
        check_all("new_op", 4'b0001, 4'b0000, 0, 0);
        drive(4'b0000, z, z);
        check_all("new_op+1", 4'b0000, 4'b0000, 0, 1);
        drive(4'b0000, z, z);
        check_all("new_op+2", 4'b0000, 4'b0000, 0, 1);
        drive(4'b0000, z, z);
        check_all("new_op+3", 4'b0000, 4'b0001, 25, 1);
        drive(4'b0000, z, z);
        check_all("new_op+4", 4'b0000, 4'b0000, 25, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
